// File: rtl/tpu_pkg.sv
// Shared TPU types and constants.
//   instr_type      : 80-bit TPU instruction (opcode | length | buffer_addr | acc_addr),
//                     opcode in bits [79:72], acc_addr in bits [15:0]
//   seq_state_type  : instruction sequencer state encoding
//   SYNC_OPCODE_DEFAULT : opcode that marks a synchronize point
package tpu_pkg;

   localparam logic [7:0] SYNC_OPCODE_DEFAULT = 8'hFF;

   typedef struct packed {
      logic [7:0]  opcode;
      logic [31:0] length;
      logic [23:0] buffer_addr;
      logic [15:0] acc_addr;
   } instr_type;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      ISSUE,
      WAIT_SYNC,
      DONE
   } seq_state_type;

endpackage

// File: rtl/tpu_prog_mem.sv
// Program memory for the instruction sequencer.
// One synchronous write port, one registered read port (1-cycle latency).
// rd_data only changes on a read enable, so it holds the last fetched slot.
//   clk      : clock
//   we       : write strobe
//   wr_addr  : write address
//   wr_data  : instruction to store
//   re       : read enable
//   rd_addr  : read address
//   rd_data  : registered read data
module tpu_prog_mem
   import tpu_pkg::*;
#(
   parameter int PROG_DEPTH      = 64,
   parameter int PROG_ADDR_WIDTH = $clog2(PROG_DEPTH)
) (
   input  logic                       clk,
   input  logic                       we,
   input  logic [PROG_ADDR_WIDTH-1:0] wr_addr,
   input  instr_type                  wr_data,
   input  logic                       re,
   input  logic [PROG_ADDR_WIDTH-1:0] rd_addr,
   output instr_type                  rd_data
);

   instr_type mem [PROG_DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
      if (re) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/tpu_instr_sequencer.sv
// Streams a host-loaded program of 80-bit instructions into the TPU
// instruction FIFO (lower/middle/upper word write interface), gated by
// instr_fifo_full. Optional stall after each sync opcode, and repeat of the
// whole program loop_count extra times.
//
// Ports:
//   clk, rst              : clock, async active-high reset
//   prog_we/addr/data     : host program load (ignored and flagged while busy)
//   prog_len              : instructions per pass (1..PROG_DEPTH)
//   loop_count            : extra passes
//   wait_sync_en          : stall after sync opcode until synchronize
//   start, abort          : control pulses (abort dominates)
//   instr_fifo_full       : TPU FIFO back-pressure
//   synchronize           : TPU sync acknowledge
//   *_instr_word          : instruction words to the TPU
//   instr_write_enable    : 3'b111 on a write cycle
//   busy, done, error     : status (done is a pulse, error is sticky)
//   issued_count          : writes since the last accepted start
//
// state     | meaning
// IDLE      | waiting for start
// FETCH     | slot 0 arriving from memory, prefetch of slot 1 issued
// ISSUE     | instruction register valid, written when FIFO not full
// WAIT_SYNC | sync opcode written, waiting for synchronize
// DONE      | one-cycle completion pulse
module tpu_instr_sequencer
   import tpu_pkg::*;
#(
   parameter int         PROG_DEPTH      = 64,
   parameter int         PROG_ADDR_WIDTH = $clog2(PROG_DEPTH),
   parameter int         LOOP_WIDTH      = 8,
   parameter logic [7:0] SYNC_OPCODE     = SYNC_OPCODE_DEFAULT
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       prog_we,
   input  logic [PROG_ADDR_WIDTH-1:0] prog_addr,
   input  instr_type                  prog_data,
   input  logic [PROG_ADDR_WIDTH:0]   prog_len,
   input  logic [LOOP_WIDTH-1:0]      loop_count,
   input  logic                       wait_sync_en,
   input  logic                       start,
   input  logic                       abort,
   input  logic                       instr_fifo_full,
   input  logic                       synchronize,
   output logic [31:0]                lower_instr_word,
   output logic [31:0]                middle_instr_word,
   output logic [15:0]                upper_instr_word,
   output logic [2:0]                 instr_write_enable,
   output logic                       busy,
   output logic                       done,
   output logic                       error,
   output logic [31:0]                issued_count
);

   localparam int AW = PROG_ADDR_WIDTH;
   localparam logic [AW:0] DEPTH_L = (AW+1)'(PROG_DEPTH);

   seq_state_type         state;
   instr_type             ir;
   logic [AW-1:0]         pc;
   logic [LOOP_WIDTH-1:0] pass;
   logic [AW:0]           len_q;
   logic [LOOP_WIDTH-1:0] loop_q;
   logic                  wsync_q;
   logic                  sync_final;
   logic                  issue_valid;

   instr_type             rd_data;
   logic                  mem_re;
   logic [AW-1:0]         mem_raddr;
   logic                  mem_we;

   logic                  len_ok;
   logic                  wr_fire;
   logic [AW:0]           last_full;
   logic                  pc_is_last;
   logic [AW-1:0]         pc_next;
   logic [AW-1:0]         pc_next2;
   logic                  more_passes;
   logic                  final_write;
   logic                  is_sync;

   assign len_ok      = (prog_len != '0) && (prog_len <= DEPTH_L);
   assign wr_fire     = (state == ISSUE) && issue_valid && !instr_fifo_full && !abort;
   assign last_full   = len_q - (AW+1)'(1);
   assign pc_is_last  = ({1'b0, pc} == last_full);
   assign pc_next     = pc_is_last ? '0 : pc + AW'(1);
   // rd_data always holds slot pc_next, so a write prefetches the slot after it
   assign pc_next2    = ({1'b0, pc_next} == last_full) ? '0 : pc_next + AW'(1);
   assign more_passes = (pass < loop_q);
   assign final_write = pc_is_last && !more_passes;
   assign is_sync     = (ir.opcode == SYNC_OPCODE);
   assign mem_we      = prog_we && !busy;

   always_comb begin
      mem_re    = 1'b0;
      mem_raddr = '0;
      unique case (state)
         IDLE: begin
            mem_re    = start && len_ok;
            mem_raddr = '0;
         end
         FETCH: begin
            mem_re    = 1'b1;
            mem_raddr = (last_full == '0) ? '0 : AW'(1);
         end
         ISSUE: begin
            mem_re    = wr_fire;
            mem_raddr = pc_next2;
         end
         default: begin
            mem_re    = 1'b0;
            mem_raddr = '0;
         end
      endcase
   end

   tpu_prog_mem #(
      .PROG_DEPTH      (PROG_DEPTH),
      .PROG_ADDR_WIDTH (AW)
   ) u_prog_mem (
      .clk     (clk),
      .we      (mem_we),
      .wr_addr (prog_addr),
      .wr_data (prog_data),
      .re      (mem_re),
      .rd_addr (mem_raddr),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         ir           <= '0;
         pc           <= '0;
         pass         <= '0;
         len_q        <= '0;
         loop_q       <= '0;
         wsync_q      <= 1'b0;
         sync_final   <= 1'b0;
         issue_valid  <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
         issued_count <= '0;
      end else begin
         done <= 1'b0;
         if (prog_we && busy) begin
            error <= 1'b1;
         end
         if (abort) begin
            state       <= IDLE;
            busy        <= 1'b0;
            issue_valid <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (start) begin
                     if (len_ok) begin
                        error        <= 1'b0;
                        issued_count <= '0;
                        pc           <= '0;
                        pass         <= '0;
                        len_q        <= prog_len;
                        loop_q       <= loop_count;
                        wsync_q      <= wait_sync_en;
                        busy         <= 1'b1;
                        state        <= FETCH;
                     end else begin
                        error <= 1'b1;
                     end
                  end
               end
               FETCH: begin
                  ir          <= rd_data;
                  issue_valid <= 1'b1;
                  state       <= ISSUE;
               end
               ISSUE: begin
                  if (wr_fire) begin
                     issued_count <= issued_count + 32'd1;
                     ir           <= rd_data;
                     pc           <= pc_next;
                     if (pc_is_last && more_passes) begin
                        pass <= pass + LOOP_WIDTH'(1);
                     end
                     if (is_sync && wsync_q) begin
                        sync_final  <= final_write;
                        issue_valid <= 1'b0;
                        state       <= WAIT_SYNC;
                     end else if (final_write) begin
                        issue_valid <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                     end
                  end
               end
               WAIT_SYNC: begin
                  if (synchronize) begin
                     if (sync_final) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                     end else begin
                        issue_valid <= 1'b1;
                        state       <= ISSUE;
                     end
                  end
               end
               DONE: begin
                  state <= IDLE;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

   assign lower_instr_word   = ir[31:0];
   assign middle_instr_word  = ir[63:32];
   assign upper_instr_word   = ir[79:64];
   assign instr_write_enable = {3{wr_fire}};

endmodule

// File: tb/tb_tpu_instr_sequencer.sv
module tb_tpu_instr_sequencer;
   import tpu_pkg::*;

   localparam int DEPTH = 64;
   localparam int AW    = 6;
   localparam int NLOG  = 64;

   logic            clk = 1'b0;
   logic            rst;
   logic            prog_we;
   logic [AW-1:0]   prog_addr;
   instr_type       prog_data;
   logic [AW:0]     prog_len;
   logic [7:0]      loop_count;
   logic            wait_sync_en;
   logic            start;
   logic            abort;
   logic            instr_fifo_full;
   logic            synchronize;
   logic [31:0]     lower_instr_word;
   logic [31:0]     middle_instr_word;
   logic [15:0]     upper_instr_word;
   logic [2:0]      instr_write_enable;
   logic            busy;
   logic            done;
   logic            error;
   logic [31:0]     issued_count;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [2:0]  we_log    [NLOG];
   logic [79:0] word_log  [NLOG];
   logic        busy_log  [NLOG];
   logic        done_log  [NLOG];
   logic        error_log [NLOG];

   always #5 clk = ~clk;

   tpu_instr_sequencer #(
      .PROG_DEPTH (DEPTH),
      .LOOP_WIDTH (8)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .prog_we            (prog_we),
      .prog_addr          (prog_addr),
      .prog_data          (prog_data),
      .prog_len           (prog_len),
      .loop_count         (loop_count),
      .wait_sync_en       (wait_sync_en),
      .start              (start),
      .abort              (abort),
      .instr_fifo_full    (instr_fifo_full),
      .synchronize        (synchronize),
      .lower_instr_word   (lower_instr_word),
      .middle_instr_word  (middle_instr_word),
      .upper_instr_word   (upper_instr_word),
      .instr_write_enable (instr_write_enable),
      .busy               (busy),
      .done               (done),
      .error              (error),
      .issued_count       (issued_count)
   );

   // hand-built instructions: {opcode, length, buffer_addr, acc_addr}
   localparam logic [79:0] I_LDW  = {8'h08, 32'd14, 24'h000000, 16'h0000};
   localparam logic [79:0] I_MM   = {8'h20, 32'd14, 24'h000003, 16'h0010};
   localparam logic [79:0] I_SIG  = {8'h89, 32'd14, 24'h00000E, 16'h0020};
   localparam logic [79:0] I_SYNC = {8'hFF, 32'd0,  24'h000000, 16'h0000};
   localparam logic [79:0] I_A    = {8'h10, 32'hCAFE0001, 24'hABCDEF, 16'h1234};
   localparam logic [79:0] I_B    = {8'h30, 32'h5555AAAA, 24'h0F0F0F, 16'hBEEF};
   localparam logic [79:0] I_JUNK = {8'h77, 32'hDEADBEEF, 24'h777777, 16'h7777};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int addr, input logic [79:0] data);
      prog_we   = 1'b1;
      prog_addr = AW'(addr);
      prog_data = instr_type'(data);
      tick();
      prog_we   = 1'b0;
   endtask

   // Drives start in cycle 0 and logs outputs at each negedge; cycle c runs
   // from posedge c (+1) to posedge c+1. -1 disables an event.
   task automatic run_capture(input int max_c, input int full_lo, input int full_hi,
                              input int sync_c, input int abort_c, input int pwe_c);
      for (int c = 0; c < max_c; c++) begin
         start           = (c == 0);
         instr_fifo_full = (c >= full_lo) && (c <= full_hi);
         synchronize     = (c == sync_c);
         abort           = (c == abort_c);
         prog_we         = (c == pwe_c);
         prog_addr       = '0;
         prog_data       = instr_type'(I_JUNK);
         @(negedge clk);
         we_log[c]    = instr_write_enable;
         word_log[c]  = {upper_instr_word, middle_instr_word, lower_instr_word};
         busy_log[c]  = busy;
         done_log[c]  = done;
         error_log[c] = error;
         tick();
      end
      start = 0; instr_fifo_full = 0; synchronize = 0; abort = 0; prog_we = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #3;
      tests_run++;
      if ({lower_instr_word, middle_instr_word, upper_instr_word} !== 80'h0) begin
         tests_failed++;
         $display("FAIL reset_words got %h %h %h want 0", upper_instr_word, middle_instr_word, lower_instr_word);
      end
      tests_run++;
      if ({instr_write_enable, busy, done, error} !== 6'b0) begin
         tests_failed++;
         $display("FAIL reset_ctrl got we=%b busy=%b done=%b err=%b want 0", instr_write_enable, busy, done, error);
      end
      tests_run++;
      if (issued_count !== 32'd0) begin
         tests_failed++;
         $display("FAIL reset_count got %0d want 0", issued_count);
      end
      @(negedge clk);
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      logic [79:0] exp [4];
      exp[0] = I_LDW; exp[1] = I_MM; exp[2] = I_SIG; exp[3] = I_SYNC;
      for (int i = 0; i < 4; i++) load(i, exp[i]);
      prog_len = 7'd4; loop_count = 8'd0; wait_sync_en = 1'b0;
      run_capture(12, -1, -1, -1, -1, -1);
      for (int c = 0; c < 12; c++) begin
         logic [2:0] we_exp;
         we_exp = (c >= 2 && c <= 5) ? 3'b111 : 3'b000;
         tests_run++;
         if (we_log[c] !== we_exp) begin
            tests_failed++;
            $display("FAIL basic_we cycle %0d got %b want %b", c, we_log[c], we_exp);
         end
         if (c >= 2 && c <= 5) begin
            tests_run++;
            if (word_log[c] !== exp[c-2]) begin
               tests_failed++;
               $display("FAIL basic_word cycle %0d got %h want %h", c, word_log[c], exp[c-2]);
            end
         end
         tests_run++;
         if (done_log[c] !== (c == 6)) begin
            tests_failed++;
            $display("FAIL basic_done cycle %0d got %b want %b", c, done_log[c], (c == 6));
         end
      end
      tests_run++;
      if (busy_log[0] !== 1'b0 || busy_log[1] !== 1'b1 || busy_log[5] !== 1'b1 || busy_log[6] !== 1'b0) begin
         tests_failed++;
         $display("FAIL basic_busy got c0=%b c1=%b c5=%b c6=%b want 0 1 1 0",
                  busy_log[0], busy_log[1], busy_log[5], busy_log[6]);
      end
      tests_run++;
      if (issued_count !== 32'd4) begin
         tests_failed++;
         $display("FAIL basic_count got %0d want 4", issued_count);
      end
   endtask

   task automatic test_stall();
      logic [79:0] exp [4];
      int n;
      exp[0] = I_LDW; exp[1] = I_MM; exp[2] = I_SIG; exp[3] = I_SYNC;
      prog_len = 7'd4; loop_count = 8'd0; wait_sync_en = 1'b0;
      run_capture(14, 3, 5, -1, -1, -1);
      for (int c = 3; c <= 5; c++) begin
         tests_run++;
         if (we_log[c] !== 3'b000 || word_log[c] !== I_MM) begin
            tests_failed++;
            $display("FAIL stall_hold cycle %0d got we=%b word=%h want 000 %h", c, we_log[c], word_log[c], I_MM);
         end
      end
      n = 0;
      for (int c = 0; c < 14; c++) begin
         if (we_log[c] === 3'b111) begin
            if (n < 4) begin
               tests_run++;
               if (word_log[c] !== exp[n]) begin
                  tests_failed++;
                  $display("FAIL stall_order write %0d got %h want %h", n, word_log[c], exp[n]);
               end
            end
            n++;
         end
      end
      tests_run++;
      if (n != 4 || we_log[6] !== 3'b111 || done_log[9] !== 1'b1) begin
         tests_failed++;
         $display("FAIL stall_timing got writes=%0d we6=%b done9=%b want 4 111 1", n, we_log[6], done_log[9]);
      end
      tests_run++;
      if (issued_count !== 32'd4) begin
         tests_failed++;
         $display("FAIL stall_count got %0d want 4", issued_count);
      end
   endtask

   task automatic test_sync_wait();
      logic [79:0] exp [3];
      int n;
      exp[0] = I_A; exp[1] = I_SYNC; exp[2] = I_B;
      for (int i = 0; i < 3; i++) load(i, exp[i]);
      prog_len = 7'd3; loop_count = 8'd0; wait_sync_en = 1'b1;
      run_capture(20, -1, -1, 13, -1, -1);
      tests_run++;
      if (we_log[2] !== 3'b111 || we_log[3] !== 3'b111 || word_log[3] !== I_SYNC) begin
         tests_failed++;
         $display("FAIL sync_pre got we2=%b we3=%b word3=%h want 111 111 %h", we_log[2], we_log[3], word_log[3], I_SYNC);
      end
      n = 0;
      for (int c = 4; c <= 13; c++) if (we_log[c] !== 3'b000) n++;
      tests_run++;
      if (n != 0) begin
         tests_failed++;
         $display("FAIL sync_stall got %0d write cycles while waiting want 0", n);
      end
      tests_run++;
      if (we_log[14] !== 3'b111 || word_log[14] !== I_B) begin
         tests_failed++;
         $display("FAIL sync_resume got we=%b word=%h want 111 %h", we_log[14], word_log[14], I_B);
      end
      tests_run++;
      if (done_log[15] !== 1'b1 || issued_count !== 32'd3) begin
         tests_failed++;
         $display("FAIL sync_done got done15=%b count=%0d want 1 3", done_log[15], issued_count);
      end
   endtask

   task automatic test_loop();
      logic [79:0] exp [6];
      int n, dn;
      load(0, I_A); load(1, I_B);
      exp[0] = I_A; exp[1] = I_B; exp[2] = I_A; exp[3] = I_B; exp[4] = I_A; exp[5] = I_B;
      prog_len = 7'd2; loop_count = 8'd2; wait_sync_en = 1'b0;
      // a host write mid-run must be dropped and flag error
      run_capture(14, -1, -1, -1, -1, 4);
      n = 0; dn = 0;
      for (int c = 0; c < 14; c++) begin
         if (done_log[c] === 1'b1) dn++;
         if (we_log[c] === 3'b111) begin
            if (n < 6) begin
               tests_run++;
               if (c != n + 2 || word_log[c] !== exp[n]) begin
                  tests_failed++;
                  $display("FAIL loop_write %0d got cycle %0d word %h want cycle %0d word %h", n, c, word_log[c], n + 2, exp[n]);
               end
            end
            n++;
         end
      end
      tests_run++;
      if (n != 6 || dn != 1 || done_log[8] !== 1'b1) begin
         tests_failed++;
         $display("FAIL loop_totals got writes=%0d dones=%0d done8=%b want 6 1 1", n, dn, done_log[8]);
      end
      tests_run++;
      if (issued_count !== 32'd6 || error !== 1'b1) begin
         tests_failed++;
         $display("FAIL loop_status got count=%0d error=%b want 6 1", issued_count, error);
      end
   endtask

   task automatic test_abort_reset();
      int dn;
      load(0, I_LDW); load(1, I_MM); load(2, I_SIG); load(3, I_A); load(4, I_B);
      prog_len = 7'd5; loop_count = 8'd0; wait_sync_en = 1'b0;
      run_capture(10, -1, -1, -1, 4, -1);
      dn = 0;
      for (int c = 0; c < 10; c++) if (done_log[c] === 1'b1) dn++;
      tests_run++;
      if (we_log[2] !== 3'b111 || we_log[3] !== 3'b111 || we_log[4] !== 3'b000) begin
         tests_failed++;
         $display("FAIL abort_we got we2=%b we3=%b we4=%b want 111 111 000", we_log[2], we_log[3], we_log[4]);
      end
      tests_run++;
      if (busy_log[4] !== 1'b1 || busy_log[5] !== 1'b0 || dn != 0) begin
         tests_failed++;
         $display("FAIL abort_status got busy4=%b busy5=%b dones=%0d want 1 0 0", busy_log[4], busy_log[5], dn);
      end
      tests_run++;
      if (issued_count !== 32'd2 || error !== 1'b0) begin
         tests_failed++;
         $display("FAIL abort_count got count=%0d error=%b want 2 0", issued_count, error);
      end
      // async reset in the middle of the write stream
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      #2;
      tests_run++;
      if (instr_write_enable !== 3'b111) begin
         tests_failed++;
         $display("FAIL arst_pre got we=%b want 111", instr_write_enable);
      end
      rst = 1'b1;
      #1;
      tests_run++;
      if ({lower_instr_word, middle_instr_word, upper_instr_word, instr_write_enable, busy, done, error} !== 86'h0
          || issued_count !== 32'd0) begin
         tests_failed++;
         $display("FAIL arst_outputs got words=%h%h%h we=%b busy=%b done=%b err=%b count=%0d want all 0",
                  upper_instr_word, middle_instr_word, lower_instr_word, instr_write_enable, busy, done, error, issued_count);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      tick();
   endtask

   task automatic test_error();
      int n;
      load(0, I_A);
      loop_count = 8'd0; wait_sync_en = 1'b0;
      prog_len = 7'd65;
      run_capture(5, -1, -1, -1, -1, -1);
      n = 0;
      for (int c = 0; c < 5; c++) if (we_log[c] !== 3'b000 || busy_log[c] !== 1'b0) n++;
      tests_run++;
      if (error_log[1] !== 1'b1 || n != 0) begin
         tests_failed++;
         $display("FAIL err_len_over got error=%b active_cycles=%0d want 1 0", error_log[1], n);
      end
      prog_len = 7'd1;
      run_capture(6, -1, -1, -1, -1, -1);
      tests_run++;
      if (error_log[1] !== 1'b0 || we_log[2] !== 3'b111 || word_log[2] !== I_A || done_log[3] !== 1'b1) begin
         tests_failed++;
         $display("FAIL err_clear got error=%b we2=%b word2=%h done3=%b want 0 111 %h 1",
                  error_log[1], we_log[2], word_log[2], done_log[3], I_A);
      end
      prog_len = 7'd0;
      run_capture(5, -1, -1, -1, -1, -1);
      n = 0;
      for (int c = 0; c < 5; c++) if (we_log[c] !== 3'b000 || busy_log[c] !== 1'b0) n++;
      tests_run++;
      if (error_log[1] !== 1'b1 || n != 0 || issued_count !== 32'd1) begin
         tests_failed++;
         $display("FAIL err_len_zero got error=%b active_cycles=%0d count=%0d want 1 0 1", error_log[1], n, issued_count);
      end
   endtask

   initial begin
      prog_we = 0; prog_addr = '0; prog_data = '0; prog_len = '0; loop_count = '0;
      wait_sync_en = 0; start = 0; abort = 0; instr_fifo_full = 0; synchronize = 0;
      test_reset();
      test_basic();
      test_stall();
      test_sync_wait();
      test_loop();
      test_abort_reset();
      test_error();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout simulation did not complete");
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/tpu_instr_sequencer.md
Name: tpu_instr_sequencer

Overview:
- Parametrised hardware instruction feeder for the TPU.
- Holds a host-loaded program of 80-bit TPU instructions and streams it into the TPU instruction FIFO through the lower/middle/upper word write interface. Writes are gated by instr_fifo_full.
- Optionally stalls after each SYNCHRONIZE instruction until the TPU raises synchronize, and supports repeating the program N times.
- Sits between the host/AXI register block and the tpu top.

Parameters:
- PROG_DEPTH, 64, number of instruction slots in the program memory (power of two, ≥2).
- PROG_ADDR_WIDTH, $clog2(PROG_DEPTH), program address width.
- LOOP_WIDTH, 8, width of the repeat counter.
- SYNC_OPCODE, 8'hFF, opcode that triggers a synchronize wait.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- prog_we  in  1  program memory write strobe
- prog_addr  in  PROG_ADDR_WIDTH  program write address
- prog_data  in  instr_type (80)  instruction to store
- prog_len  in  PROG_ADDR_WIDTH+1  number of instructions to run (1..PROG_DEPTH)
- loop_count  in  LOOP_WIDTH  extra passes (total passes = loop_count+1)
- wait_sync_en  in  1  enable the stall after SYNC_OPCODE
- start  in  1  single-cycle start pulse
- abort  in  1  single-cycle abort
- instr_fifo_full  in  1  TPU instruction FIFO full
- synchronize  in  1  TPU synchronize output
- lower_instr_word  out  32  instr[31:0]
- middle_instr_word  out  32  instr[63:32]
- upper_instr_word  out  16  instr[79:64]
- instr_write_enable  out  3  3'b111 on a write cycle, else 3'b000
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse on normal completion
- error  out  1  sticky error flag; cleared by the next accepted start
- issued_count  out  32  instructions written since the last accepted start

Behaviour:
- Reset (async, immediate): state=IDLE. All outputs 0 (instr words 0, write enable 3'b000, busy/done/error 0, issued_count 0). Program memory contents are not reset.
- Program memory: synchronous write, synchronous read with 1-cycle latency. prog_we while busy=1 is ignored and sets error.
- States:
  - IDLE: on start, check prog_len.
    - prog_len==0 or prog_len>PROG_DEPTH: set error, stay IDLE.
    - Otherwise: clear error and issued_count, pc=0, pass=0, busy=1, read slot 0, go to FETCH.
  - FETCH: one cycle; read data is latched into the instruction register; go to ISSUE.
  - ISSUE: instr_write_enable=3'b111 in any cycle where instr_fifo_full=0, with words driven from the instruction register in that same cycle.
    - While full=1: hold the instruction register and words, write enable 3'b000.
    - Each write: issued_count+1; pc advances; the next slot is prefetched so sustained throughput is one instruction per cycle.
    - If the written opcode==SYNC_OPCODE and wait_sync_en=1: go to WAIT_SYNC.
    - After the last slot (pc==prog_len-1): if pass<loop_count, pass+1, pc=0, continue; else go to DONE.
  - WAIT_SYNC: synchronize is sampled starting the cycle after the SYNC write. When synchronize=1, resume ISSUE with the prefetched instruction, or go to DONE if the SYNC was the final instruction.
  - DONE: done=1 for one cycle, busy=0, go to IDLE.
- Latency: first write occurs 2 cycles after the start cycle (start, FETCH, write).
- start while busy=1 is ignored (no error).
- abort takes priority over all other inputs:
  - Next state is IDLE, busy=0, write enable 3'b000 in the abort cycle.
  - No done pulse; issued_count keeps its value.
- abort and start in the same cycle: abort wins.
- pc wraps only via the prog_len compare, never via address overflow.
- issued_count wraps modulo 2^32.
- Outputs are registered except instr_write_enable, which is the registered ISSUE-valid flag ANDed with !instr_fifo_full.

Decomposition:
- tpu_pkg gains:
  - SYNC_OPCODE_DEFAULT constant;
  - seq_state_type enum (IDLE, FETCH, ISSUE, WAIT_SYNC, DONE);
  - instr_type is reused for the 80-bit instruction (opcode 8, length 32, buffer_addr 24, acc_addr 16).
- One sub-module: tpu_prog_mem, an instr_type-wide single-port-write / registered-read RAM of PROG_DEPTH entries.

Test Plan:
1. Load 4 instructions (0x08 load-weight len 14, 0x20 matmul len 14, 0x89 sigmoid buffer_addr 0x0E, 0xFF sync); prog_len=4, loop_count=0, wait_sync_en=0, full=0; start → writes on cycles 2..5 with matching words, then done pulse; issued_count=4.
2. Same program with full asserted on cycles 3–5 → write enable 3'b000 and words held during the stall; all 4 instructions written exactly once, in order.
3. wait_sync_en=1; sync placed at slot 1 of a 3-instruction program; synchronize raised 10 cycles later → no write until 1 cycle after synchronize; total issued_count=3.
4. prog_len=2, loop_count=2 → 6 writes in order A,B,A,B,A,B, then one done pulse.
5. start with prog_len=0, and a separate start with prog_len=PROG_DEPTH+1 → error=1, busy stays 0, no writes. A later valid start clears error.
6. abort asserted after 2 writes of a 5-instruction program → write enable 0 in the abort cycle, busy=0 next cycle, no done pulse, issued_count=2. Async rst mid-ISSUE → all outputs 0 immediately.
